// File: rtl/cpu_pmp_pkg.sv
// Shared PMP types, CSR addresses and address-match helpers for the
// runtime-programmable PMP unit.
package cpu_pmp_pkg;

    typedef logic [11:0] csr_t;

    localparam csr_t CSR_PMPCFG0  = 12'h3A0;
    localparam csr_t CSR_PMPADDR0 = 12'h3B0;

    localparam int PMP_MAX_ENTRIES = 16;

    localparam logic [1:0] PMPCFG_A_OFF   = 2'd0;
    localparam logic [1:0] PMPCFG_A_TOR   = 2'd1;
    localparam logic [1:0] PMPCFG_A_NA4   = 2'd2;
    localparam logic [1:0] PMPCFG_A_NAPOT = 2'd3;

    typedef struct packed {
        logic       locked;
        logic [1:0] reserved;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    typedef struct packed {
        pmp_cfg_t    cfg;
        logic [31:0] addr;
    } pmp_entry_t;

    // Bits set in the mask must agree; the trailing-ones run and the first
    // zero above it are the don't-care part of the region.
    function automatic logic [31:0] pmp_napot_mask(input logic [31:0] addr);
        return ~(addr ^ (addr + 32'd1));
    endfunction

endpackage

// File: rtl/cpu_pmp_match.sv
// Combinational permission lookup for one address against all PMP entries,
// lowest matching entry wins.
module cpu_pmp_match
    import cpu_pmp_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  pmp_entry_t [ENTRIES-1:0] entries,
    input  logic [31:0]              addr,
    input  logic                     mmode,
    output logic [2:0]               rwx,
    output logic                     hit
);

    logic [31:0]        word;
    logic [ENTRIES-1:0] match;
    logic               unused_addr_bits;

    assign word             = {2'b00, addr[31:2]};
    assign unused_addr_bits = ^addr[1:0];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic [31:0] lo;
        logic        tor_m;
        logic        na4_m;
        logic        napot_m;
        logic        unused_rsv;

        if (i == 0) begin : g_first
            assign lo = '0;
        end else begin : g_rest
            assign lo = entries[i-1].addr;
        end

        // An inverted TOR range (lo >= top) can never satisfy both bounds.
        assign tor_m      = (word >= lo) && (word < entries[i].addr);
        assign na4_m      = (word == entries[i].addr);
        assign napot_m    = ((word ^ entries[i].addr) & pmp_napot_mask(entries[i].addr)) == '0;
        assign unused_rsv = ^entries[i].cfg.reserved;

        assign match[i] = ((entries[i].cfg.a == PMPCFG_A_TOR)   && tor_m) ||
                          ((entries[i].cfg.a == PMPCFG_A_NA4)   && na4_m) ||
                          ((entries[i].cfg.a == PMPCFG_A_NAPOT) && napot_m);
    end

    always_comb begin
        hit = 1'b0;
        rwx = mmode ? 3'b111 : 3'b000;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit = 1'b1;
                rwx = (entries[i].cfg.locked || !mmode)
                      ? {entries[i].cfg.x, entries[i].cfg.w, entries[i].cfg.r}
                      : 3'b111;
            end
        end
    end

endmodule

// File: rtl/cpu_pmp.sv
// Runtime-programmable PMP: CSR-writable cfg/addr table with lock enforcement
// and LOOKUP_PORTS independent permission lookups.
module cpu_pmp
    import cpu_pmp_pkg::*;
#(
    parameter int                      ENTRIES      = 16,
    parameter int                      LOOKUP_PORTS = 2,
    parameter int                      LOOKUP_REG   = 0,
    parameter logic [ENTRIES-1:0][7:0]  RESET_CFG    = '0,
    parameter logic [ENTRIES-1:0][31:0] RESET_ADDR   = '0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  csr_t                          read_addr_i,
    input  logic                          read_enable_i,
    output logic [31:0]                   read_data_o,
    input  csr_t                          write_addr_i,
    input  logic [31:0]                   write_data_i,
    input  logic                          write_enable_i,
    input  logic [LOOKUP_PORTS-1:0][31:0] lookup_addr_i,
    input  logic [LOOKUP_PORTS-1:0]       lookup_mmode_i,
    output logic [LOOKUP_PORTS-1:0][2:0]  lookup_rwx_o,
    output logic [LOOKUP_PORTS-1:0]       lookup_hit_o
);

    pmp_entry_t [ENTRIES-1:0] entry_q;

    csr_t               rd_cfg_off;
    csr_t               rd_addr_off;
    csr_t               wr_cfg_off;
    csr_t               wr_addr_off;
    logic               rd_cfg_hit;
    logic               rd_addr_hit;
    logic               wr_cfg_hit;
    logic               wr_addr_hit;
    logic [31:0]        rd_data;
    logic [ENTRIES-1:0] tor_lock;

    function automatic pmp_cfg_t cfg_legalize(input logic [7:0] b);
        pmp_cfg_t c;
        c          = pmp_cfg_t'(b);
        c.reserved = 2'b00;
        c.w        = b[1] & b[0];
        return c;
    endfunction

    // Offsets wrap for addresses below the base, so one compare bounds both ends.
    assign rd_cfg_off  = read_addr_i  - CSR_PMPCFG0;
    assign rd_addr_off = read_addr_i  - CSR_PMPADDR0;
    assign wr_cfg_off  = write_addr_i - CSR_PMPCFG0;
    assign wr_addr_off = write_addr_i - CSR_PMPADDR0;
    assign rd_cfg_hit  = rd_cfg_off  < csr_t'(ENTRIES / 4);
    assign rd_addr_hit = rd_addr_off < csr_t'(ENTRIES);
    assign wr_cfg_hit  = wr_cfg_off  < csr_t'(ENTRIES / 4);
    assign wr_addr_hit = wr_addr_off < csr_t'(ENTRIES);

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (rd_cfg_hit && rd_cfg_off == csr_t'(i / 4))
                rd_data[8*(i%4) +: 8] = entry_q[i].cfg;
            if (rd_addr_hit && rd_addr_off == csr_t'(i))
                rd_data = entry_q[i].addr;
        end
    end

    // A locked TOR entry also freezes the address below it, its range base.
    always_comb begin
        tor_lock = '0;
        for (int i = 0; i < ENTRIES - 1; i++)
            tor_lock[i] = entry_q[i+1].cfg.locked && (entry_q[i+1].cfg.a == PMPCFG_A_TOR);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_q[i].cfg  <= pmp_cfg_t'(RESET_CFG[i]);
                entry_q[i].addr <= RESET_ADDR[i];
            end
            read_data_o <= '0;
        end else begin
            read_data_o <= read_enable_i ? rd_data : '0;
            if (write_enable_i) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (wr_cfg_hit && wr_cfg_off == csr_t'(i / 4) && !entry_q[i].cfg.locked)
                        entry_q[i].cfg <= cfg_legalize(write_data_i[8*(i%4) +: 8]);
                    if (wr_addr_hit && wr_addr_off == csr_t'(i) &&
                        !entry_q[i].cfg.locked && !tor_lock[i])
                        entry_q[i].addr <= write_data_i;
                end
            end
        end
    end

    for (genvar p = 0; p < LOOKUP_PORTS; p++) begin : g_port
        logic [2:0] rwx_p0;
        logic       hit_p0;

        cpu_pmp_match #(
            .ENTRIES (ENTRIES)
        ) u_match (
            .entries (entry_q),
            .addr    (lookup_addr_i[p]),
            .mmode   (lookup_mmode_i[p]),
            .rwx     (rwx_p0),
            .hit     (hit_p0)
        );

        if (LOOKUP_REG != 0) begin : g_reg
            logic [2:0] rwx_p1;
            logic       hit_p1;

            // Registered lookup stage
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    rwx_p1 <= 3'b000;
                    hit_p1 <= 1'b0;
                end else begin
                    rwx_p1 <= rwx_p0;
                    hit_p1 <= hit_p0;
                end
            end

            assign lookup_rwx_o[p] = rwx_p1;
            assign lookup_hit_o[p] = hit_p1;
        end else begin : g_comb
            assign lookup_rwx_o[p] = rwx_p0;
            assign lookup_hit_o[p] = hit_p0;
        end
    end

endmodule

// File: tb/tb_cpu_pmp.sv
// Bench for cpu_pmp: a combinational and a registered instance share stimulus
// and are compared every cycle against a range-based reference model.
module tb_cpu_pmp;
    import cpu_pmp_pkg::*;

    localparam int N = 16;
    localparam int P = 2;
    localparam logic [N-1:0][7:0]  RCFG  = 128'h07 << 96;
    localparam logic [N-1:0][31:0] RADDR = 512'h1234_5678 << (32 * 12);

    logic                clk_i = 1'b0;
    logic                rst_i = 1'b0;
    csr_t                read_addr_i = '0;
    logic                read_enable_i = 1'b0;
    csr_t                write_addr_i = '0;
    logic [31:0]         write_data_i = '0;
    logic                write_enable_i = 1'b0;
    logic [P-1:0][31:0]  lookup_addr_i = '0;
    logic [P-1:0]        lookup_mmode_i = '0;
    logic [31:0]         read_data0, read_data1;
    logic [P-1:0][2:0]   rwx0, rwx1;
    logic [P-1:0]        hit0, hit1;

    int checks = 0;
    int errors = 0;

    cpu_pmp #(.ENTRIES(N), .LOOKUP_PORTS(P), .LOOKUP_REG(0), .RESET_CFG(RCFG), .RESET_ADDR(RADDR)) u_comb (
        .clk_i(clk_i), .rst_i(rst_i),
        .read_addr_i(read_addr_i), .read_enable_i(read_enable_i), .read_data_o(read_data0),
        .write_addr_i(write_addr_i), .write_data_i(write_data_i), .write_enable_i(write_enable_i),
        .lookup_addr_i(lookup_addr_i), .lookup_mmode_i(lookup_mmode_i),
        .lookup_rwx_o(rwx0), .lookup_hit_o(hit0));

    cpu_pmp #(.ENTRIES(N), .LOOKUP_PORTS(P), .LOOKUP_REG(1), .RESET_CFG(RCFG), .RESET_ADDR(RADDR)) u_reg (
        .clk_i(clk_i), .rst_i(rst_i),
        .read_addr_i(read_addr_i), .read_enable_i(read_enable_i), .read_data_o(read_data1),
        .write_addr_i(write_addr_i), .write_data_i(write_data_i), .write_enable_i(write_enable_i),
        .lookup_addr_i(lookup_addr_i), .lookup_mmode_i(lookup_mmode_i),
        .lookup_rwx_o(rwx1), .lookup_hit_o(hit1));

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: table contents as plain byte/word arrays
    logic [7:0]  m_cfg  [N];
    logic [31:0] m_addr [N];
    logic [2:0]  e_rwx_reg [P];
    logic        e_hit_reg [P];
    logic [31:0] e_rd;

    function automatic logic [31:0] mdl_read(input csr_t a);
        logic [31:0] d = '0;
        if (a >= 12'h3A0 && a < 12'h3A4) begin
            int k = int'(a - 12'h3A0);
            d = {m_cfg[4*k+3], m_cfg[4*k+2], m_cfg[4*k+1], m_cfg[4*k]};
        end else if (a >= 12'h3B0 && a < 12'h3C0) begin
            d = m_addr[int'(a - 12'h3B0)];
        end
        return d;
    endfunction

    task automatic mdl_write(input csr_t a, input logic [31:0] d);
        if (a >= 12'h3A0 && a < 12'h3A4) begin
            int k = int'(a - 12'h3A0);
            for (int j = 0; j < 4; j++) begin
                logic [7:0] b = d[8*j +: 8];
                if (!m_cfg[4*k+j][7]) begin
                    b[6:5] = 2'b00;
                    if (b[1:0] == 2'b10) b[1] = 1'b0;
                    m_cfg[4*k+j] = b;
                end
            end
        end else if (a >= 12'h3B0 && a < 12'h3C0) begin
            int i = int'(a - 12'h3B0);
            logic frozen = m_cfg[i][7];
            if (i < N - 1 && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'd1) frozen = 1'b1;
            if (!frozen) m_addr[i] = d;
        end
    endtask

    // Each entry is turned into a word range [lo, hi) and tested by plain compares.
    task automatic mdl_lookup(input logic [31:0] a, input logic mm, output logic [2:0] rwx, output logic hit);
        longint w = longint'(a) >> 2;
        logic done = 1'b0;
        rwx = mm ? 3'b111 : 3'b000;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            longint lo = 0, hi = 0;
            int t = 0;
            case (m_cfg[i][4:3])
                2'd1: begin lo = (i == 0) ? 0 : longint'(m_addr[i-1]); hi = longint'(m_addr[i]); end
                2'd2: begin lo = longint'(m_addr[i]); hi = lo + 1; end
                2'd3: begin
                    while (t < 32 && m_addr[i][t]) t++;
                    hi = longint'(1) << (t + 1);
                    lo = (longint'(m_addr[i]) / hi) * hi;
                    hi = lo + hi;
                end
                default: begin lo = 0; hi = 0; end
            endcase
            if (!done && w >= lo && w < hi) begin
                done = 1'b1;
                hit  = 1'b1;
                rwx  = (m_cfg[i][7] || !mm) ? m_cfg[i][2:0] : 3'b111;
            end
        end
    endtask

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                m_cfg[i]  = RCFG[i];
                m_addr[i] = RADDR[i];
            end
            e_rd = '0;
            for (int p = 0; p < P; p++) begin
                e_rwx_reg[p] = 3'b000;
                e_hit_reg[p] = 1'b0;
            end
        end else begin
            for (int p = 0; p < P; p++) mdl_lookup(lookup_addr_i[p], lookup_mmode_i[p], e_rwx_reg[p], e_hit_reg[p]);
            e_rd = read_enable_i ? mdl_read(read_addr_i) : 32'h0;
            if (write_enable_i) mdl_write(write_addr_i, write_data_i);
        end
    end

    logic [2:0] c_rwx;
    logic       c_hit;
    always @(negedge clk_i) begin
        if (!rst_i) begin
            for (int p = 0; p < P; p++) begin
                mdl_lookup(lookup_addr_i[p], lookup_mmode_i[p], c_rwx, c_hit);
                chk("cmp_comb_rwx", 32'(rwx0[p]), 32'(c_rwx));
                chk("cmp_comb_hit", 32'(hit0[p]), 32'(c_hit));
                chk("cmp_reg_rwx",  32'(rwx1[p]), 32'(e_rwx_reg[p]));
                chk("cmp_reg_hit",  32'(hit1[p]), 32'(e_hit_reg[p]));
            end
            chk("cmp_rdata_comb", read_data0, e_rd);
            chk("cmp_rdata_reg",  read_data1, e_rd);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input csr_t a, input logic [31:0] d);
        write_addr_i = a; write_data_i = d; write_enable_i = 1'b1;
        tick();
        write_enable_i = 1'b0;
    endtask

    task automatic rd(input csr_t a, output logic [31:0] d);
        read_addr_i = a; read_enable_i = 1'b1;
        tick();
        read_enable_i = 1'b0;
        d = read_data0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic look(input int p, input logic [31:0] a, input logic mm,
                        input logic [2:0] er, input logic eh, input string nm);
        lookup_addr_i[p] = a; lookup_mmode_i[p] = mm;
        #1;
        chk({nm, "_rwx"}, 32'(rwx0[p]), 32'(er));
        chk({nm, "_hit"}, 32'(hit0[p]), 32'(eh));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [31:0] d;
    initial begin
        // Reset defaults
        rst_i = 1'b1;
        lookup_addr_i[0] = 32'h1000_0000; lookup_mmode_i[0] = 1'b0;
        tick();
        chk("rst_reg_rwx", 32'(rwx1[0]), 32'h0);
        chk("rst_reg_hit", 32'(hit1[0]), 32'h0);
        chk("rst_rdata", read_data0, 32'h0);
        tick();
        rst_i = 1'b0;
        tick();
        look(0, 32'h1000_0000, 1'b0, 3'b000, 1'b0, "rst_user");
        look(0, 32'h1000_0000, 1'b1, 3'b111, 1'b0, "rst_mach");
        rd(CSR_PMPCFG0, d);      chk("rst_pmpcfg0", d, 32'h0);
        rd(CSR_PMPCFG0 + 3, d);  chk("rst_pmpcfg3", d, 32'h0000_0007);
        rd(CSR_PMPADDR0 + 12, d); chk("rst_pmpaddr12", d, 32'h1234_5678);

        // NAPOT 4 KiB at 0x1000_0000
        wr(CSR_PMPADDR0, 32'h0400_01FF);
        wr(CSR_PMPCFG0, 32'h0000_001B);
        look(0, 32'h1000_0FFC, 1'b0, 3'b011, 1'b1, "napot_in");
        look(0, 32'h1000_1000, 1'b0, 3'b000, 1'b0, "napot_out");

        // TOR and priority
        do_reset();
        wr(CSR_PMPADDR0, 32'h0000_0400);
        wr(CSR_PMPADDR0 + 1, 32'h0000_0800);
        wr(CSR_PMPCFG0, 32'h0000_0D00);
        look(0, 32'h0000_1000, 1'b0, 3'b101, 1'b1, "tor_in");
        look(0, 32'h0000_0FFC, 1'b0, 3'b000, 1'b0, "tor_below");
        wr(CSR_PMPCFG0, 32'h0000_0D11);
        look(0, 32'h0000_1000, 1'b0, 3'b001, 1'b1, "prio_na4");

        // Lock
        do_reset();
        wr(CSR_PMPADDR0, 32'h0400_01FF);
        wr(CSR_PMPCFG0, 32'h0000_0099);
        wr(CSR_PMPCFG0, 32'h0000_001F);
        rd(CSR_PMPCFG0, d);  chk("lock_cfg_keep", d, 32'h0000_0099);
        wr(CSR_PMPADDR0, 32'h0);
        rd(CSR_PMPADDR0, d); chk("lock_addr_keep", d, 32'h0400_01FF);
        look(0, 32'h1000_0010, 1'b1, 3'b001, 1'b1, "lock_mach");
        wr(CSR_PMPADDR0 + 1, 32'h0800_0000);
        wr(CSR_PMPCFG0, 32'h0000_1000);
        look(1, 32'h2000_0000, 1'b1, 3'b111, 1'b1, "unlocked_mach");
        look(1, 32'h2000_0000, 1'b0, 3'b000, 1'b1, "unlocked_user");

        // TOR lock freezes previous address; reset mid-write
        do_reset();
        wr(CSR_PMPADDR0, 32'h0000_0100);
        wr(CSR_PMPCFG0, 32'h0000_8800);
        wr(CSR_PMPADDR0, 32'h0000_0200);
        rd(CSR_PMPADDR0, d); chk("torlock_prev", d, 32'h0000_0100);
        rd(CSR_PMPCFG0, d);  chk("torlock_cfg", d, 32'h0000_8800);
        write_addr_i = CSR_PMPCFG0; write_data_i = 32'h1F1F_1F1F; write_enable_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0; write_enable_i = 1'b0;
        tick();
        rd(CSR_PMPCFG0, d);      chk("midwrite_cfg0", d, 32'h0);
        rd(CSR_PMPCFG0 + 4, d);  chk("unimpl_cfg", d, 32'h0);

        // WARL, same-cycle read/write, registered lookup latency
        wr(CSR_PMPCFG0, 32'h0000_0062);
        rd(CSR_PMPCFG0, d); chk("warl_cfg0", d, 32'h0);
        wr(CSR_PMPADDR0 + 3, 32'h11);
        write_addr_i = CSR_PMPADDR0 + 3; write_data_i = 32'h22; write_enable_i = 1'b1;
        read_addr_i  = CSR_PMPADDR0 + 3; read_enable_i = 1'b1;
        tick();
        write_enable_i = 1'b0; read_enable_i = 1'b0;
        chk("rw_same_old", read_data0, 32'h11);
        tick();
        chk("rd_idle_zero", read_data0, 32'h0);
        rd(CSR_PMPADDR0 + 3, d); chk("rw_same_new", d, 32'h22);
        wr(CSR_PMPADDR0 + 2, 32'h0C00_0000);
        wr(CSR_PMPCFG0, 32'h0015_0000);
        lookup_addr_i[1] = 32'h0; lookup_mmode_i[1] = 1'b0;
        tick();
        look(1, 32'h3000_0000, 1'b0, 3'b101, 1'b1, "reglat_comb");
        chk("reglat_before", 32'(rwx1[1]), 32'h0);
        tick();
        chk("reglat_after_rwx", 32'(rwx1[1]), 32'h5);
        chk("reglat_after_hit", 32'(hit1[1]), 32'h1);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if (c % 800 == 799) begin
                write_addr_i = CSR_PMPCFG0 + csr_t'($urandom % 4); write_data_i = $urandom; write_enable_i = 1'b1;
                @(negedge clk_i);
                rst_i = 1'b1;
                tick();
                rst_i = 1'b0; write_enable_i = 1'b0;
            end
            write_enable_i = ($urandom % 3 == 0);
            case ($urandom % 3)
                0: begin
                    write_addr_i = CSR_PMPCFG0 + csr_t'($urandom % 5);
                    for (int j = 0; j < 4; j++) begin
                        logic [7:0] b = 8'($urandom);
                        if ($urandom % 12 != 0) b[7] = 1'b0;
                        write_data_i[8*j +: 8] = b;
                    end
                end
                1: begin
                    write_addr_i = CSR_PMPADDR0 + csr_t'($urandom % 17);
                    case ($urandom % 3)
                        0: write_data_i = $urandom % 4096;
                        1: write_data_i = (($urandom % 4096) << ($urandom % 12)) | ((32'h1 << ($urandom % 10)) - 1);
                        default: write_data_i = $urandom;
                    endcase
                end
                default: begin write_addr_i = csr_t'($urandom); write_data_i = $urandom; end
            endcase
            read_enable_i = $urandom % 2;
            read_addr_i = ($urandom % 4 == 0) ? csr_t'($urandom) :
                          (($urandom % 2) ? CSR_PMPCFG0 + csr_t'($urandom % 5) : CSR_PMPADDR0 + csr_t'($urandom % 17));
            for (int p = 0; p < P; p++) begin
                int e = $urandom % N;
                lookup_mmode_i[p] = $urandom % 2;
                if ($urandom % 4 == 0) lookup_addr_i[p] = $urandom;
                else lookup_addr_i[p] = {m_addr[e][29:0], 2'b00} + 32'($urandom % 64) - 32'd32;
            end
            tick();
        end
        write_enable_i = 1'b0; read_enable_i = 1'b0;
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
